// File: rtl/pc_trace_checker.sv
// pc_trace_checker: compares a stored expected fetch-address trace, in order,
// against the observed pc stream. Reports per-sample mismatch pulses, a
// saturating error count and the first failing entry.
module pc_trace_checker #(
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DEPTH       = 1024,
   parameter int unsigned       IDX_W       = 10,
   parameter logic [ADDR_W-1:0] CMP_MASK    = {ADDR_W{1'b1}},
   parameter bit                STOP_ON_ERR = 1'b0,
   parameter int unsigned       ERR_W       = 16
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              ld_en,
   input  logic [IDX_W-1:0]  ld_idx,
   input  logic [ADDR_W-1:0] ld_data,
   input  logic              start,
   input  logic [IDX_W:0]    trace_len,
   input  logic              pc_valid,
   input  logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [IDX_W:0]    cur_idx,
   output logic [ADDR_W-1:0] exp_pc,
   output logic              mismatch,
   output logic [ERR_W-1:0]  err_count,
   output logic              first_err_vld,
   output logic [IDX_W:0]    first_err_idx,
   output logic [ADDR_W-1:0] first_err_pc
);

   typedef enum logic [1:0] {StIdle, StRun, StDone, StHalt} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] mem [DEPTH];
   logic [IDX_W:0]    len_q, len_d;
   logic [IDX_W:0]    cur_idx_q, cur_idx_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic              mis_q, mis_d;
   logic              fv_q, fv_d;
   logic [IDX_W:0]    fidx_q, fidx_d;
   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic [IDX_W:0]    idx_inc;
   logic              miss;
   logic              last;

   // Only the low IDX_W bits address the array; cur_idx == DEPTH wraps harmlessly.
   assign exp_pc  = mem[cur_idx_q[IDX_W-1:0]];
   assign miss    = ((pc ^ exp_pc) & CMP_MASK) != '0;
   assign idx_inc = cur_idx_q + (IDX_W+1)'(1);
   assign last    = idx_inc == len_q;

   // Trace array write port; not reset, frozen while a run is in progress.
   always_ff @(posedge clk) begin
      if (ld_en && (state_q != StRun)) begin
         mem[ld_idx] <= ld_data;
      end
   end

   // Next-state and run bookkeeping.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cur_idx_d = cur_idx_q;
      err_d     = err_q;
      mis_d     = 1'b0;
      fv_d      = fv_q;
      fidx_d    = fidx_q;
      fpc_d     = fpc_q;
      case (state_q)
         StRun: begin
            if (pc_valid) begin
               cur_idx_d = idx_inc;
               if (miss) begin
                  mis_d = 1'b1;
                  if (err_q != '1) begin
                     err_d = err_q + ERR_W'(1);
                  end
                  if (!fv_q) begin
                     fv_d   = 1'b1;
                     fidx_d = cur_idx_q;
                     fpc_d  = pc;
                  end
               end
               if (miss && STOP_ON_ERR) begin
                  state_d = StHalt;
               end else if (last) begin
                  state_d = StDone;
               end
            end
         end
         default: begin
            if (start) begin
               len_d     = trace_len;
               cur_idx_d = '0;
               err_d     = '0;
               fv_d      = 1'b0;
               fidx_d    = '0;
               fpc_d     = '0;
               state_d   = (trace_len == '0) ? StDone : StRun;
            end
         end
      endcase
   end

   // State registers; async reset aborts any run but leaves the trace intact.
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state_q   <= StIdle;
         len_q     <= '0;
         cur_idx_q <= '0;
         err_q     <= '0;
         mis_q     <= 1'b0;
         fv_q      <= 1'b0;
         fidx_q    <= '0;
         fpc_q     <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cur_idx_q <= cur_idx_d;
         err_q     <= err_d;
         mis_q     <= mis_d;
         fv_q      <= fv_d;
         fidx_q    <= fidx_d;
         fpc_q     <= fpc_d;
      end
   end

   assign busy          = state_q == StRun;
   assign done          = (state_q == StDone) || (state_q == StHalt);
   assign pass          = done && (err_q == '0);
   assign cur_idx       = cur_idx_q;
   assign mismatch      = mis_q;
   assign err_count     = err_q;
   assign first_err_vld = fv_q;
   assign first_err_idx = fidx_q;
   assign first_err_pc  = fpc_q;

endmodule

// File: tb/tb_pc_trace_checker.sv
// Bench for pc_trace_checker: three instances (plain, stop-on-error, bit-31
// masked) share one stimulus stream and are checked against a behavioural model.
module tb_pc_trace_checker;

   localparam int NC = 3;

   logic        clk = 1'b0;
   logic        RESET;
   logic        ld_en;
   logic [3:0]  ld_idx;
   logic [31:0] ld_data;
   logic        start;
   logic [4:0]  trace_len;
   logic        pc_valid;
   logic [31:0] pc;

   logic [NC-1:0]        busy_v, done_v, pass_v, mis_v, fv_v;
   logic [NC-1:0][4:0]   cidx_v, fidx_v;
   logic [NC-1:0][31:0]  exp_v, fpc_v;
   logic [NC-1:0][2:0]   err_v;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state per instance: ph 0 idle, 1 running, 2 done, 3 halted.
   int          ph     [NC];
   int          idx    [NC];
   int          len_m  [NC];
   int          err    [NC];
   bit          fv     [NC];
   int          fidx   [NC];
   logic [31:0] fpc    [NC];
   bit          mis    [NC];
   logic [31:0] mm     [NC][16];

   always #5 clk = ~clk;

   pc_trace_checker #(.ADDR_W(32), .DEPTH(16), .IDX_W(4), .CMP_MASK(32'hFFFF_FFFF),
                      .STOP_ON_ERR(1'b0), .ERR_W(3)) u_plain (
      .clk(clk), .RESET(RESET), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
      .start(start), .trace_len(trace_len), .pc_valid(pc_valid), .pc(pc),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .cur_idx(cidx_v[0]),
      .exp_pc(exp_v[0]), .mismatch(mis_v[0]), .err_count(err_v[0]),
      .first_err_vld(fv_v[0]), .first_err_idx(fidx_v[0]), .first_err_pc(fpc_v[0]));

   pc_trace_checker #(.ADDR_W(32), .DEPTH(16), .IDX_W(4), .CMP_MASK(32'hFFFF_FFFF),
                      .STOP_ON_ERR(1'b1), .ERR_W(3)) u_stop (
      .clk(clk), .RESET(RESET), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
      .start(start), .trace_len(trace_len), .pc_valid(pc_valid), .pc(pc),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .cur_idx(cidx_v[1]),
      .exp_pc(exp_v[1]), .mismatch(mis_v[1]), .err_count(err_v[1]),
      .first_err_vld(fv_v[1]), .first_err_idx(fidx_v[1]), .first_err_pc(fpc_v[1]));

   pc_trace_checker #(.ADDR_W(32), .DEPTH(16), .IDX_W(4), .CMP_MASK(32'h7FFF_FFFF),
                      .STOP_ON_ERR(1'b0), .ERR_W(3)) u_mask (
      .clk(clk), .RESET(RESET), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
      .start(start), .trace_len(trace_len), .pc_valid(pc_valid), .pc(pc),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .cur_idx(cidx_v[2]),
      .exp_pc(exp_v[2]), .mismatch(mis_v[2]), .err_count(err_v[2]),
      .first_err_vld(fv_v[2]), .first_err_idx(fidx_v[2]), .first_err_pc(fpc_v[2]));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] cmask(input int c);
      return (c == 2) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
   endfunction

   function automatic bit cstop(input int c);
      return c == 1;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         ph[c] = 0; idx[c] = 0; len_m[c] = 0; err[c] = 0;
         fv[c] = 0; fidx[c] = 0; fpc[c] = '0; mis[c] = 0;
      end
   endtask

   // Apply the rules for one rising edge given the currently driven inputs.
   task automatic model_edge();
      for (int c = 0; c < NC; c++) begin
         mis[c] = 0;
         if (ph[c] == 1) begin
            if (pc_valid) begin
               bit bad;
               int at;
               at = idx[c];
               bad = ((pc ^ mm[c][at % 16]) & cmask(c)) != 0;
               idx[c] = at + 1;
               if (bad) begin
                  mis[c] = 1;
                  if (err[c] < 7) err[c] = err[c] + 1;
                  if (!fv[c]) begin
                     fv[c] = 1; fidx[c] = at; fpc[c] = pc;
                  end
               end
               if (bad && cstop(c)) ph[c] = 3;
               else if (at == len_m[c] - 1) ph[c] = 2;
            end
         end else begin
            if (ld_en) mm[c][ld_idx] = ld_data;
            if (start) begin
               len_m[c] = int'(trace_len);
               idx[c] = 0; err[c] = 0; fv[c] = 0; fidx[c] = 0; fpc[c] = '0;
               ph[c] = (trace_len == 0) ? 2 : 1;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NC; c++) begin
         check($sformatf("c%0d.busy", c), 64'(busy_v[c]), 64'(ph[c] == 1));
         check($sformatf("c%0d.done", c), 64'(done_v[c]), 64'(ph[c] >= 2));
         check($sformatf("c%0d.pass", c), 64'(pass_v[c]), 64'(ph[c] >= 2 && err[c] == 0));
         check($sformatf("c%0d.cur_idx", c), 64'(cidx_v[c]), 64'(idx[c]));
         check($sformatf("c%0d.mismatch", c), 64'(mis_v[c]), 64'(mis[c]));
         check($sformatf("c%0d.err_count", c), 64'(err_v[c]), 64'(err[c]));
         check($sformatf("c%0d.first_err_vld", c), 64'(fv_v[c]), 64'(fv[c]));
         check($sformatf("c%0d.first_err_idx", c), 64'(fidx_v[c]), 64'(fidx[c]));
         check($sformatf("c%0d.first_err_pc", c), 64'(fpc_v[c]), 64'(fpc[c]));
      end
      if (ph[0] == 1) check("c0.exp_pc", 64'(exp_v[0]), 64'(mm[0][idx[0] % 16]));
   endtask

   // One clock: model the edge, then sample at the following falling edge.
   task automatic cycle();
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic load(input int i, input logic [31:0] d);
      ld_en = 1'b1; ld_idx = 4'(i); ld_data = d;
      cycle();
      ld_en = 1'b0;
   endtask

   task automatic start_run(input int len);
      start = 1'b1; trace_len = 5'(len);
      cycle();
      start = 1'b0;
   endtask

   task automatic feed(input logic [31:0] p, input bit v);
      pc_valid = v; pc = p;
      cycle();
      pc_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] t1 [4];
      int nvalid;
      t1[0] = 32'h8000_0000; t1[1] = 32'h8000_002C;
      t1[2] = 32'h8000_0030; t1[3] = 32'h8000_0034;
      RESET = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0; start = 1'b0;
      trace_len = '0; pc_valid = 1'b0; pc = '0;
      for (int c = 0; c < NC; c++) for (int i = 0; i < 16; i++) mm[c][i] = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      RESET = 1'b1;
      for (int i = 0; i < 16; i++) load(i, 32'h0);

      // Clean 4-entry run.
      for (int i = 0; i < 4; i++) load(i, t1[i]);
      start_run(4);
      for (int k = 0; k < 4; k++) feed(t1[k], 1'b1);
      check("t1.pass", 64'(pass_v[0]), 64'd1);
      check("t1.cur_idx", 64'(cidx_v[0]), 64'd4);
      check("t1.err", 64'(err_v[0]), 64'd0);

      // Third sample wrong: plain counts, stop instance halts.
      start_run(4);
      feed(t1[0], 1'b1);
      feed(t1[1], 1'b1);
      feed(32'h8000_0038, 1'b1);
      check("t2.mismatch", 64'(mis_v[0]), 64'd1);
      check("t3.halt_busy", 64'(busy_v[1]), 64'd0);
      check("t3.halt_done", 64'(done_v[1]), 64'd1);
      check("t3.halt_idx", 64'(cidx_v[1]), 64'd3);
      feed(t1[3], 1'b1);
      check("t2.mismatch_clear", 64'(mis_v[0]), 64'd0);
      check("t2.err", 64'(err_v[0]), 64'd1);
      check("t2.first_idx", 64'(fidx_v[0]), 64'd2);
      check("t2.first_pc", 64'(fpc_v[0]), 64'h8000_0038);
      check("t2.pass", 64'(pass_v[0]), 64'd0);
      check("t3.idx_after", 64'(cidx_v[1]), 64'd3);

      // Bit 31 masked out on the third instance only.
      load(0, 32'h8000_03B8);
      start_run(1);
      feed(32'h0000_03B8, 1'b1);
      check("mask.pass", 64'(pass_v[2]), 64'd1);
      check("mask.plain_pass", 64'(pass_v[0]), 64'd0);

      // Gapped pc_valid over an 8-entry trace.
      for (int i = 0; i < 8; i++) load(i, $urandom);
      start_run(8);
      nvalid = 0;
      for (int k = 0; nvalid < 8 && k < 64; k++) begin
         feed(mm[0][nvalid], (k % 3) == 0);
         if ((k % 3) == 0) nvalid++;
      end
      check("gap.done", 64'(done_v[0]), 64'd1);
      check("gap.idx", 64'(cidx_v[0]), 64'd8);

      // Zero-length run.
      start_run(0);
      check("len0.done", 64'(done_v[0]), 64'd1);
      check("len0.pass", 64'(pass_v[0]), 64'd1);

      // Reset mid-run, then rerun the retained trace.
      start_run(8);
      for (int k = 0; k < 5; k++) feed(mm[0][k], 1'b1);
      check("rst.pre_idx", 64'(cidx_v[0]), 64'd5);
      #2 RESET = 1'b0;
      #1 model_reset();
      check("rst.busy", 64'(busy_v[0]), 64'd0);
      check("rst.idx", 64'(cidx_v[0]), 64'd0);
      check_all();
      @(negedge clk);
      RESET = 1'b1;
      start_run(8);
      for (int k = 0; k < 8; k++) feed(mm[0][k], 1'b1);
      check("rerun.pass", 64'(pass_v[0]), 64'd1);

      // Load and start together: run sees the new entry.
      ld_en = 1'b1; ld_idx = 4'd0; ld_data = 32'h1234_5670;
      start = 1'b1; trace_len = 5'd1;
      cycle();
      ld_en = 1'b0; start = 1'b0;
      feed(32'h1234_5670, 1'b1);
      check("ldstart.pass", 64'(pass_v[0]), 64'd1);

      // Randomized runs with stray loads/starts during RUN.
      for (int r = 0; r < 24; r++) begin
         int len;
         int rate;
         int guard;
         len  = (r == 0) ? 16 : $urandom_range(0, 16);
         rate = (r % 4 == 0) ? 100 : $urandom_range(0, 40);
         for (int i = 0; i < 16; i++) load(i, $urandom);
         start_run(len);
         guard = 0;
         while (ph[0] == 1 && guard < 300) begin
            pc_valid = $urandom_range(0, 99) < 70;
            pc = mm[0][idx[0] % 16];
            if ($urandom_range(0, 99) < rate)
               pc = ($urandom_range(0, 1) == 1) ? (pc ^ 32'h8000_0000) : 32'($urandom);
            ld_en = $urandom_range(0, 99) < 8;
            ld_idx = 4'($urandom);
            ld_data = $urandom;
            start = $urandom_range(0, 99) < 5;
            trace_len = 5'(len);
            cycle();
            ld_en = 1'b0; start = 1'b0; pc_valid = 1'b0;
            guard++;
         end
         check("rnd.finished", 64'(busy_v[0]), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
